saw_receiver: RTL

Receiving end of the stop-and-wait ARQ link; it pairs with the SAW transmitter FSM. The block accepts one frame at a time: a sequence bit, a payload and a CRC. It checks the CRC and compares the sequence bit against the one it expects next. New frames are delivered downstream and acknowledged; duplicates are re-acknowledged without delivery; corrupted frames are dropped silently so the transmitter's timer forces a retransmit.

---
 rtl/saw_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/saw_receiver.sv
// Stop-and-wait ARQ receiver: CRC check, duplicate filtering, delivery and ACK return.
module saw_receiver #(
  parameter int unsigned BW     = 10,
  parameter int unsigned CRC_BW = 4,
  parameter int unsigned CNT_BW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BW-1:0]          frame_in,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [BW-2-CRC_BW:0]   data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   ack_valid,
  output logic                   ack_seq,
  input  logic                   ack_ready,
  output logic                   expected_seq,
  output logic [CNT_BW-1:0]      err_cnt,
  output logic [CNT_BW-1:0]      dup_cnt
);

  localparam int unsigned DW = BW - 1 - CRC_BW;   // payload width
  localparam int unsigned MW = BW - CRC_BW;       // bits covered by the CRC (seq + payload)
  localparam logic [CRC_BW-1:0] POLY = CRC_BW'(3); // x^4 + x + 1, implicit top term

  typedef enum logic [1:0] {IDLE, CHECK, DELIVER, ACK} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     cap_q, cap_d;
  logic              exp_d;
  logic [CNT_BW-1:0] err_d, dup_d;
  logic              frame_ready_d, data_valid_d, ack_valid_d, ack_seq_d;
  logic [DW-1:0]     data_out_d;
  logic              crc_ok_c;

  // MSB-first serial CRC, zero init, no reflection, no final XOR
  function automatic logic [CRC_BW-1:0] crc_calc(input logic [MW-1:0] msg);
    logic [CRC_BW-1:0] c;
    logic              fb;
    c = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      fb = c[CRC_BW-1] ^ msg[i];
      c  = {c[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign crc_ok_c = (crc_calc(cap_q[BW-1:CRC_BW]) == cap_q[CRC_BW-1:0]);

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d       = state_q;
    cap_d         = cap_q;
    exp_d         = expected_seq;
    err_d         = err_cnt;
    dup_d         = dup_cnt;
    frame_ready_d = 1'b0;
    data_valid_d  = 1'b0;
    data_out_d    = '0;
    ack_valid_d   = 1'b0;
    ack_seq_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          cap_d   = frame_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!crc_ok_c) begin
          if (err_cnt != '1) err_d = err_cnt + CNT_BW'(1);
          state_d = IDLE;
        end else if (cap_q[BW-1] == expected_seq) begin
          state_d = DELIVER;
        end else begin
          if (dup_cnt != '1) dup_d = dup_cnt + CNT_BW'(1);
          state_d = ACK;
        end
      end
      DELIVER: begin
        if (data_ready) begin
          exp_d   = ~expected_seq;
          state_d = ACK;
        end
      end
      ACK: begin
        if (ack_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    frame_ready_d = (state_d == IDLE);
    data_valid_d  = (state_d == DELIVER);
    ack_valid_d   = (state_d == ACK);
    if (data_valid_d) data_out_d = cap_d[BW-2:CRC_BW];
    if (ack_valid_d)  ack_seq_d  = cap_d[BW-1];
  end

  // State, capture, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      expected_seq <= 1'b0;
      err_cnt      <= '0;
      dup_cnt      <= '0;
      frame_ready  <= 1'b0;
      data_valid   <= 1'b0;
      data_out     <= '0;
      ack_valid    <= 1'b0;
      ack_seq      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      expected_seq <= exp_d;
      err_cnt      <= err_d;
      dup_cnt      <= dup_d;
      frame_ready  <= frame_ready_d;
      data_valid   <= data_valid_d;
      data_out     <= data_out_d;
      ack_valid    <= ack_valid_d;
      ack_seq      <= ack_seq_d;
    end
  end

endmodule
